wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port among NUM_REQ thread contexts, each driving its own MEM/WB stage output.

---
 rtl/wb_port_arbiter.sv | 105 ++++++++++
 tb/tb_wb_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Round-robin arbiter that gives the single register-file write
//            port to one of NUM_REQ per-thread MEM/WB stages each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*REG_W-1:0]     req_reg_dst,
  input  logic [NUM_REQ*DATA_W-1:0]    req_alu,
  input  logic [NUM_REQ*DATA_W-1:0]    req_lmd,
  input  logic [NUM_REQ-1:0]           req_mem_write,
  input  logic [NUM_REQ-1:0]           req_alu_write,
  input  logic                         rf_hold,
  output logic                         rf_we,
  output logic [$clog2(NUM_REQ)-1:0]   rf_tid,
  output logic [REG_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata
);

  localparam int c_TID_W = $clog2(NUM_REQ);

  logic [c_TID_W-1:0] r_rr_ptr;
  logic               r_we;
  logic [c_TID_W-1:0] r_tid;
  logic [REG_W-1:0]   r_waddr;
  logic [DATA_W-1:0]  r_wdata;

  logic               w_found;
  logic [c_TID_W-1:0] w_gidx;
  logic [c_TID_W-1:0] w_scan_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [REG_W-1:0]   w_dst;
  logic [DATA_W-1:0]  w_data;
  logic               w_mw;
  logic               w_aw;
  logic               w_we;

  // Scan from the round-robin pointer; the first valid requester wins.
  always_comb begin
    w_found    = 1'b0;
    w_gidx     = '0;
    w_scan_idx = '0;
    w_grant    = '0;
    if (!rst && !rf_hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_scan_idx = c_TID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_found && req_valid[w_scan_idx]) begin
          w_found = 1'b1;
          w_gidx  = w_scan_idx;
        end
      end
    end
    if (w_found) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign req_ready = w_grant;

  always_comb begin
    w_dst  = req_reg_dst[int'(w_gidx)*REG_W +: REG_W];
    w_mw   = req_mem_write[w_gidx];
    w_aw   = req_alu_write[w_gidx];
    w_data = w_mw ? req_lmd[int'(w_gidx)*DATA_W +: DATA_W]
                  : req_alu[int'(w_gidx)*DATA_W +: DATA_W];
    // Writes to r0 and flagless requests are consumed without a write.
    w_we   = w_found && (w_mw || w_aw) && (w_dst != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_we     <= 1'b0;
      r_tid    <= '0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= w_we;
      if (w_found) begin
        r_rr_ptr <= c_TID_W'((int'(w_gidx) + 1) % NUM_REQ);
      end
      if (w_we) begin
        r_tid   <= w_gidx;
        r_waddr <= w_dst;
        r_wdata <= w_data;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_tid   = r_tid;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed scenarios plus randomized traffic for wb_port_arbiter,
//            checked against a request-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*RW-1:0] req_reg_dst;
  logic [N*DW-1:0] req_alu;
  logic [N*DW-1:0] req_lmd;
  logic [N-1:0]    req_mem_write;
  logic [N-1:0]    req_alu_write;
  logic            rf_hold;
  logic            rf_we;
  logic [1:0]      rf_tid;
  logic [RW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;

  int total = 0;
  int bad   = 0;

  // Reference model state: whose turn it is, and what the write port shows.
  int            m_ptr;
  logic          m_we;
  logic [1:0]    m_tid;
  logic [RW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  wb_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg_dst(req_reg_dst), .req_alu(req_alu), .req_lmd(req_lmd),
    .req_mem_write(req_mem_write), .req_alu_write(req_alu_write),
    .rf_hold(rf_hold), .rf_we(rf_we), .rf_tid(rf_tid),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant();
    if (rst || rf_hold) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] grant_mask(input int g);
    logic [N-1:0] m;
    m = '0;
    if (g >= 0) m[g] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_tid = '0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic model_commit(input int g);
    logic [RW-1:0] dst;
    m_we = 1'b0;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      dst   = req_reg_dst[g*RW +: RW];
      if ((req_mem_write[g] || req_alu_write[g]) && dst != 0) begin
        m_we    = 1'b1;
        m_tid   = 2'(g);
        m_waddr = dst;
        m_wdata = req_mem_write[g] ? req_lmd[g*DW +: DW] : req_alu[g*DW +: DW];
      end
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [RW-1:0] dst,
                         input logic [DW-1:0] alu, input logic [DW-1:0] lmd,
                         input logic mw, input logic aw);
    req_valid[i]           = v;
    req_reg_dst[i*RW +: RW] = dst;
    req_alu[i*DW +: DW]    = alu;
    req_lmd[i*DW +: DW]    = lmd;
    req_mem_write[i]       = mw;
    req_alu_write[i]       = aw;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_reg_dst = '0; req_alu = '0; req_lmd = '0;
    req_mem_write = '0; req_alu_write = '0; rf_hold = 1'b0;
  endtask

  // Leaves the bench one time unit after a rising edge, reset released.
  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    req_valid = '1;
    req_alu_write = '1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++;
    if ({rf_we, rf_tid, rf_waddr, rf_wdata} !== '0)
      begin bad++; $display("FAIL reset_outputs: got we=%b tid=%0d waddr=%0d wdata=%h want all 0", rf_we, rf_tid, rf_waddr, rf_wdata); end
    rst = 1'b0;
    clear_reqs();
    model_reset();
  endtask

  task automatic test_single();
    int g;
    set_req(0, 1'b1, 5'd3, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    #1 g = exp_grant();
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    @(posedge clk);
    model_commit(g);
    #1 clear_reqs();
    total++;
    if (rf_we !== 1'b1 || rf_tid !== 2'd0 || rf_waddr !== 5'd3 || rf_wdata !== 32'hDEADBEEF)
      begin bad++; $display("FAIL single_write: got we=%b tid=%0d waddr=%0d wdata=%h want 1/0/3/deadbeef", rf_we, rf_tid, rf_waddr, rf_wdata); end
  endtask

  task automatic test_fairness();
    int g;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'(32'h100 * i + 7), 32'h0, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1 g = exp_grant();
      total++;
      if (req_ready !== grant_mask(c % N))
        begin bad++; $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, grant_mask(c % N)); end
      @(posedge clk);
      model_commit(g);
      #1;
      total++;
      if (rf_we !== 1'b1 || rf_tid !== 2'(c % N) || rf_wdata !== 32'(32'h100 * (c % N) + 7))
        begin bad++; $display("FAIL fair_write[%0d]: got we=%b tid=%0d wdata=%h want 1/%0d", c, rf_we, rf_tid, rf_wdata, c % N); end
    end
    clear_reqs();
  endtask

  task automatic test_skip();
    int g;
    do_reset();
    set_req(1, 1'b1, 5'd9, 32'h1111, 32'h0, 1'b0, 1'b1);
    #1 g = exp_grant();
    @(posedge clk);
    model_commit(g);
    #1 clear_reqs();
    set_req(0, 1'b1, 5'd10, 32'hA0, 32'h0, 1'b0, 1'b1);
    set_req(3, 1'b1, 5'd13, 32'hA3, 32'h0, 1'b0, 1'b1);
    #1 g = exp_grant();
    total++;
    if (req_ready !== 4'b1000) begin bad++; $display("FAIL skip_first: got %b want 1000", req_ready); end
    @(posedge clk);
    model_commit(g);
    #1 req_valid[3] = 1'b0;
    total++;
    if (rf_we !== 1'b1 || rf_tid !== 2'd3 || rf_wdata !== 32'hA3)
      begin bad++; $display("FAIL skip_write3: got we=%b tid=%0d wdata=%h want 1/3/a3", rf_we, rf_tid, rf_wdata); end
    #1 g = exp_grant();
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL skip_second: got %b want 0001", req_ready); end
    @(posedge clk);
    model_commit(g);
    #1 clear_reqs();
    total++;
    if (rf_we !== 1'b1 || rf_tid !== 2'd0 || rf_wdata !== 32'hA0)
      begin bad++; $display("FAIL skip_write0: got we=%b tid=%0d wdata=%h want 1/0/a0", rf_we, rf_tid, rf_wdata); end
  endtask

  task automatic test_data_select();
    int g;
    set_req(2, 1'b1, 5'd7, 32'h22, 32'h11, 1'b1, 1'b1);
    #1 g = exp_grant();
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL sel_ready: got %b want 0100", req_ready); end
    @(posedge clk);
    model_commit(g);
    #1 req_reg_dst[2*RW +: RW] = 5'd0;
    total++;
    if (rf_we !== 1'b1 || rf_tid !== 2'd2 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11)
      begin bad++; $display("FAIL sel_lmd_wins: got we=%b tid=%0d waddr=%0d wdata=%h want 1/2/7/11", rf_we, rf_tid, rf_waddr, rf_wdata); end
    #1 g = exp_grant();
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL sel_r0_ready: got %b want 0100", req_ready); end
    @(posedge clk);
    model_commit(g);
    #1 clear_reqs();
    total++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11)
      begin bad++; $display("FAIL sel_r0_consumed: got we=%b waddr=%0d wdata=%h want 0/7/11", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_hold();
    int g;
    set_req(1, 1'b1, 5'd5, 32'h55, 32'h0, 1'b0, 1'b1);
    rf_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 g = exp_grant();
      total++;
      if (req_ready !== '0) begin bad++; $display("FAIL hold_ready[%0d]: got %b want 0000", c, req_ready); end
      @(posedge clk);
      model_commit(g);
      #1;
      total++;
      if (rf_we !== 1'b0) begin bad++; $display("FAIL hold_we[%0d]: got %b want 0", c, rf_we); end
    end
    rf_hold = 1'b0;
    #1 g = exp_grant();
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL hold_release: got %b want 0010", req_ready); end
    @(posedge clk);
    model_commit(g);
    #1 clear_reqs();
    total++;
    if (rf_we !== 1'b1 || rf_tid !== 2'd1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55)
      begin bad++; $display("FAIL hold_write: got we=%b tid=%0d waddr=%0d wdata=%h want 1/1/5/55", rf_we, rf_tid, rf_waddr, rf_wdata); end
  endtask

  task automatic test_reset_mid();
    int g;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b1, 5'(20 + i), 32'(i), 32'h0, 1'b0, 1'b1);
      #1 g = exp_grant();
      @(posedge clk);
      model_commit(g);
      #1 clear_reqs();
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(20 + i), 32'(32'hC0 + i), 32'h0, 1'b0, 1'b1);
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL rstmid_pre: got %b want 0100", req_ready); end
    rst = 1'b1;
    #1;
    total++;
    if (req_ready !== '0 || rf_we !== 1'b0)
      begin bad++; $display("FAIL rstmid_async: got ready=%b we=%b want 0000/0", req_ready, rf_we); end
    @(posedge clk);
    #1;
    total++;
    if (rf_we !== 1'b0) begin bad++; $display("FAIL rstmid_no_write: got %b want 0", rf_we); end
    rst = 1'b0;
    model_reset();
    #1 g = exp_grant();
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_first: got %b want 0001", req_ready); end
    @(posedge clk);
    model_commit(g);
    #1 clear_reqs();
    total++;
    if (rf_we !== 1'b1 || rf_tid !== 2'd0 || rf_wdata !== 32'hC0)
      begin bad++; $display("FAIL rstmid_write: got we=%b tid=%0d wdata=%h want 1/0/c0", rf_we, rf_tid, rf_wdata); end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, 5'($urandom_range(0, 3)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rf_hold = ($urandom_range(0, 3) == 0);
      #1 g = exp_grant();
      total++;
      if (req_ready !== grant_mask(g))
        begin bad++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, grant_mask(g)); end
      @(posedge clk);
      model_commit(g);
      #1;
      if (g >= 0) req_valid[g] = 1'b0;
      total++;
      if (rf_we !== m_we || rf_tid !== m_tid || rf_waddr !== m_waddr || rf_wdata !== m_wdata)
        begin bad++; $display("FAIL rand_write[%0d]: got we=%b tid=%0d waddr=%0d wdata=%h want we=%b tid=%0d waddr=%0d wdata=%h",
                              c, rf_we, rf_tid, rf_waddr, rf_wdata, m_we, m_tid, m_waddr, m_wdata); end
    end
    clear_reqs();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    model_reset();
    @(posedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_skip();
    test_data_select();
    test_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
